stream_downsize: RTL and testbench

//   Wide-to-narrow stream width converter, the inverse of stream_upsize.

---
 rtl/stream_downsize.sv | 94 +++++++++
 tb/tb_stream_downsize.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream width converter: replays the kept lanes of one wide
// beat as consecutive narrow beats, lowest lane first.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_DATA_RATIO-1:0]                   s_keep_i,
    input  logic                                      s_last_i,
    input  logic                                      s_valid_i,
    output logic                                      s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                   m_data_o,
    output logic                                      m_last_o,
    output logic                                      m_valid_o,
    input  logic                                      m_ready_i
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [T_DATA_RATIO-1:0] ONE = T_DATA_RATIO'(1);

    state_t                                  r_state, w_state_nxt;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] r_buf, w_buf_nxt;
    logic [T_DATA_RATIO-1:0]                 r_rem, w_rem_nxt;
    logic                                    r_last, w_last_nxt;

    logic [T_DATA_RATIO-1:0] w_lane_oh;
    logic [T_DATA_WIDTH-1:0] w_lane_data;
    logic                    w_one_left;
    logic                    w_send;
    logic                    w_s_fire;
    logic                    w_m_fire;

    // Two's-complement trick isolates the lowest remaining lane.
    assign w_lane_oh  = r_rem & (~r_rem + ONE);
    assign w_one_left = ((r_rem & (r_rem - ONE)) == '0);

    always_comb begin
        w_lane_data = '0;
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            if (w_lane_oh[i]) w_lane_data = w_lane_data | r_buf[i];
        end
    end

    // Outputs are gated by reset so they read idle for the whole reset window.
    assign w_send    = reset && (r_state == SEND);
    assign m_valid_o = w_send;
    assign m_data_o  = w_send ? w_lane_data : '0;
    assign m_last_o  = w_send && r_last && w_one_left;
    assign s_ready_o = reset && ((r_state == IDLE) || (w_one_left && m_ready_i));

    assign w_s_fire  = s_valid_i && s_ready_o;
    assign w_m_fire  = w_send && m_ready_i;

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_rem_nxt   = r_rem;
        w_last_nxt  = r_last;
        if (w_m_fire) begin
            w_rem_nxt = r_rem & ~w_lane_oh;
            if (w_one_left) w_state_nxt = IDLE;
        end
        if (w_s_fire) begin
            if (s_keep_i != '0) begin
                w_buf_nxt   = s_data_i;
                w_rem_nxt   = s_keep_i;
                w_last_nxt  = s_last_i;
                w_state_nxt = SEND;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values; the lane buffer is cleared on reset too so no stale data survives it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_rem   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_rem   <= w_rem_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Bench for stream_downsize: directed scenario tables on a 2-lane instance,
// a 3-lane sparse-keep case, and a randomized run against a lane-queue model.
module tb_stream_downsize;

    logic clk;
    logic reset;

    logic [1:0][3:0] s_data2;
    logic [1:0]      s_keep2;
    logic            s_last2, s_valid2, s_ready2, m_last2, m_valid2, m_ready2;
    logic [3:0]      m_data2;

    logic [2:0][3:0] s_data3;
    logic [2:0]      s_keep3;
    logic            s_last3, s_valid3, s_ready3, m_last3, m_valid3, m_ready3;
    logic [3:0]      m_data3;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       rn;
        logic       sv;
        logic [1:0] sk;
        logic [7:0] sd;
        logic       sl;
        logic       mr;
        logic       ev;
        logic [3:0] ed;
        logic       el;
        logic       er;
    } step_t;

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut2 (
        .clk(clk), .reset(reset),
        .s_data_i(s_data2), .s_keep_i(s_keep2), .s_last_i(s_last2),
        .s_valid_i(s_valid2), .s_ready_o(s_ready2),
        .m_data_o(m_data2), .m_last_o(m_last2), .m_valid_o(m_valid2),
        .m_ready_i(m_ready2)
    );

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(3)) dut3 (
        .clk(clk), .reset(reset),
        .s_data_i(s_data3), .s_keep_i(s_keep3), .s_last_i(s_last3),
        .s_valid_i(s_valid3), .s_ready_o(s_ready3),
        .m_data_o(m_data3), .m_last_o(m_last3), .m_valid_o(m_valid3),
        .m_ready_i(m_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(logic rn, logic sv, logic [1:0] sk, logic [7:0] sd,
                                 logic sl, logic mr, logic ev, logic [3:0] ed,
                                 logic el, logic er);
        return {rn, sv, sk, sd, sl, mr, ev, ed, el, er};
    endfunction

    // Drives one cycle of stimulus, samples {valid,data,last,ready} mid-cycle.
    task automatic step(input step_t s, output logic [6:0] o);
        reset    = s.rn;
        s_valid2 = s.sv;
        s_keep2  = s.sk;
        s_data2  = s.sd;
        s_last2  = s.sl;
        m_ready2 = s.mr;
        @(negedge clk);
        o = {m_valid2, m_data2, m_last2, s_ready2};
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input step_t st[$]);
        logic [6:0] o, e;
        foreach (st[i]) begin
            step(st[i], o);
            e = {st[i].ev, st[i].ed, st[i].el, st[i].er};
            n_cmp++;
            if ((st[i].ev || !st[i].rn) ? (o !== e) : ({o[6], o[0]} !== {e[6], e[0]})) begin
                n_err++;
                $display("FAIL %s[%0d]: got v/d/l/rdy=%b/%h/%b/%b want %b/%h/%b/%b",
                         name, i, o[6], o[5:2], o[1], o[0], e[6], e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset;
        step_t st[$];
        st.push_back(mk(0, 1, 2'b11, 8'hFF, 1, 1, 0, 4'h0, 0, 0));
        st.push_back(mk(0, 1, 2'b11, 8'hFF, 1, 1, 0, 4'h0, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        run_table("reset", st);
    endtask

    task automatic test_full_beat;
        step_t st[$];
        st.push_back(mk(1, 1, 2'b11, 8'hA3, 1, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'h3, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'hA, 1, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        run_table("full_beat", st);
    endtask

    task automatic test_partial;
        step_t st[$];
        st.push_back(mk(1, 1, 2'b01, 8'h05, 1, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'h5, 1, 1));
        st.push_back(mk(1, 1, 2'b10, 8'hC0, 0, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'hC, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        run_table("partial", st);
    endtask

    task automatic test_back_to_back;
        step_t st[$];
        st.push_back(mk(1, 1, 2'b11, 8'h21, 0, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 1, 2'b11, 8'h43, 0, 1, 1, 4'h1, 0, 0));
        st.push_back(mk(1, 1, 2'b11, 8'h43, 0, 1, 1, 4'h2, 0, 1));
        st.push_back(mk(1, 1, 2'b11, 8'h65, 1, 1, 1, 4'h3, 0, 0));
        st.push_back(mk(1, 1, 2'b11, 8'h65, 1, 1, 1, 4'h4, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'h5, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'h6, 1, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        run_table("back_to_back", st);
    endtask

    task automatic test_backpressure;
        step_t st[$];
        st.push_back(mk(1, 1, 2'b11, 8'h69, 1, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'h9, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 0, 1, 4'h6, 1, 0));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 0, 1, 4'h6, 1, 0));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'h6, 1, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        run_table("backpressure", st);
    endtask

    task automatic test_keep_zero;
        step_t st[$];
        st.push_back(mk(1, 1, 2'b00, 8'hFF, 0, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        run_table("keep_zero", st);
    endtask

    task automatic test_sparse_ratio3;
        logic [6:0] o;
        logic [6:0] exp_o [3];
        exp_o[0] = {1'b1, 4'h1, 1'b0, 1'b0};
        exp_o[1] = {1'b1, 4'hE, 1'b1, 1'b1};
        exp_o[2] = {1'b0, 4'h0, 1'b0, 1'b1};
        s_data3  = {4'hE, 4'h7, 4'h1};
        s_keep3  = 3'b101;
        s_last3  = 1'b1;
        s_valid3 = 1'b1;
        m_ready3 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_valid3, s_ready3} !== 2'b01) begin
            n_err++;
            $display("FAIL sparse3_idle: got v/rdy=%b/%b want 0/1", m_valid3, s_ready3);
        end
        @(posedge clk);
        #1;
        s_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = {m_valid3, m_data3, m_last3, s_ready3};
            n_cmp++;
            if (exp_o[i][6] ? (o !== exp_o[i]) : ({o[6], o[0]} !== {exp_o[i][6], exp_o[i][0]})) begin
                n_err++;
                $display("FAIL sparse3[%0d]: got v/d/l/rdy=%b/%h/%b/%b want %b/%h/%b/%b", i,
                         o[6], o[5:2], o[1], o[0], exp_o[i][6], exp_o[i][5:2], exp_o[i][1], exp_o[i][0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_send;
        step_t st[$];
        st.push_back(mk(1, 1, 2'b11, 8'hB7, 1, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 1, 4'h7, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        st.push_back(mk(1, 0, 2'b00, 8'h00, 0, 1, 0, 4'h0, 0, 1));
        run_table("reset_mid_send", st);
    endtask

    // Model: each accepted wide beat expands into its kept lanes in ascending
    // order; last rides on the highest kept lane only.
    task automatic test_random;
        logic [4:0] exp_q[$];
        logic [4:0] e;
        logic       s_acc, prev_stall, prev_l;
        logic [3:0] prev_d;
        s_acc      = 1'b1;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        s_valid2   = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c < 500) begin
                if (s_acc || !s_valid2) begin
                    s_valid2 = ($urandom_range(0, 3) != 0);
                    s_keep2  = 2'($urandom);
                    s_data2  = 8'($urandom);
                    s_last2  = 1'($urandom);
                end
            end else if (s_acc) begin
                s_valid2 = 1'b0;
            end
            m_ready2 = (c >= 500) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            s_acc = s_valid2 && s_ready2;
            if (prev_stall) begin
                n_cmp++;
                if ({m_valid2, m_data2, m_last2} !== {1'b1, prev_d, prev_l}) begin
                    n_err++;
                    $display("FAIL rand_hold@%0d: got v/d/l=%b/%h/%b want 1/%h/%b",
                             c, m_valid2, m_data2, m_last2, prev_d, prev_l);
                end
            end
            prev_stall = m_valid2 && !m_ready2;
            prev_d     = m_data2;
            prev_l     = m_last2;
            if (m_valid2 && m_ready2) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_beat@%0d: got d/l=%h/%b want no beat", c, m_data2, m_last2);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data2, m_last2} !== e) begin
                        n_err++;
                        $display("FAIL rand_beat@%0d: got d/l=%h/%b want %h/%b",
                                 c, m_data2, m_last2, e[4:1], e[0]);
                    end
                end
            end
            if (s_acc) begin
                for (int i = 0; i < 2; i++) begin
                    if (s_keep2[i]) exp_q.push_back({s_data2[i], s_last2 && ((s_keep2 >> (i + 1)) == 0)});
                end
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (exp_q.size() != 0 || m_valid2 !== 1'b0) begin
            n_err++;
            $display("FAIL rand_drain: got %0d beats pending, m_valid=%b want 0, 0", exp_q.size(), m_valid2);
        end
    endtask

    initial begin
        reset    = 1'b0;
        s_data2  = '0; s_keep2 = '0; s_last2 = 1'b0; s_valid2 = 1'b0; m_ready2 = 1'b0;
        s_data3  = '0; s_keep3 = '0; s_last3 = 1'b0; s_valid3 = 1'b0; m_ready3 = 1'b0;
        test_reset;
        test_full_beat;
        test_partial;
        test_back_to_back;
        test_backpressure;
        test_keep_zero;
        test_sparse_ratio3;
        test_reset_mid_send;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
